// File: rtl/pifo_buf_pkg.sv
// rtl/pifo_buf_pkg.sv - shared types and constants for the PIFO payload slot buffer
package pifo_buf_pkg;

  localparam int DEF_DATA_WIDTH = 289;
  localparam int DEF_DEPTH      = 64;

  // Legal read latencies: raw synchronous RAM output, or with an extra output register
  localparam int RD_LAT_RAM = 1;
  localparam int RD_LAT_REG = 2;

  typedef logic [$clog2(DEF_DEPTH)-1:0] slot_handle_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/slot_free_list.sv
// rtl/slot_free_list.sv - first-word-fall-through FIFO of free slot handles
module slot_free_list #(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] head,
  output logic [ADDR_WIDTH:0]   count
);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_addr;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/pkt_slot_buffer.sv
// rtl/pkt_slot_buffer.sv - managed payload slot buffer with free list and handle-based reads
module pkt_slot_buffer
  import pifo_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LATENCY = RD_LAT_REG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_free,
  output logic                  rdout_valid,
  output logic [DATA_WIDTH-1:0] rdout_data,
  output logic                  rdout_err,
  output logic [ADDR_WIDTH:0]   free_count,
  output logic                  init_done
);

  buf_state_t            state;
  buf_state_t            state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  init_push;

  always_comb begin
    state_nxt = state;
    init_push = 1'b0;
    case (state)
      ST_INIT: begin
        init_push = 1'b1;
        if (init_cnt == ADDR_WIDTH'(DEPTH-1)) state_nxt = ST_RUN;
      end
      ST_RUN: state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (init_push) init_cnt <= init_cnt + ADDR_WIDTH'(1);
    end
  end

  logic                  wr_fire;
  logic                  rd_fire;
  logic                  rd_hit;
  logic                  free_fire;
  logic [DEPTH-1:0]      alloc;
  logic                  fl_push;
  logic [ADDR_WIDTH-1:0] fl_push_addr;

  assign init_done    = (state == ST_RUN);
  assign rd_ready     = (state == ST_RUN);
  assign wr_ready     = (state == ST_RUN) && (free_count != '0);
  assign wr_fire      = wr_valid && wr_ready;
  assign rd_fire      = rd_valid && rd_ready;
  assign rd_hit       = alloc[rd_addr];
  // Only allocated handles go back on the list, so the list can never overflow
  assign free_fire    = rd_fire && rd_free && rd_hit;
  assign fl_push      = init_push || free_fire;
  assign fl_push_addr = init_push ? init_cnt : rd_addr;

  slot_free_list #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_free_list (
    .clk       (clk),
    .rst       (rst),
    .push      (fl_push),
    .push_addr (fl_push_addr),
    .pop       (wr_fire),
    .head      (wr_addr),
    .count     (free_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc <= '0;
    end else begin
      if (free_fire) alloc[rd_addr] <= 1'b0;
      if (wr_fire)   alloc[wr_addr] <= 1'b1;
    end
  end

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_fire) ram[wr_addr] <= wr_data;
  end

  // Read-first: the read register samples the old word when the same slot is written
  logic                  s1_valid;
  logic                  s1_err;
  logic [DATA_WIDTH-1:0] s1_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) begin
        s1_err  <= !rd_hit;
        s1_data <= ram[rd_addr];
      end
    end
  end

  generate
    if (RD_LATENCY == RD_LAT_RAM) begin : g_lat1
      assign rdout_valid = s1_valid;
      assign rdout_err   = s1_err;
      assign rdout_data  = s1_data;
    end else begin : g_lat2
      logic                  s2_valid;
      logic                  s2_err;
      logic [DATA_WIDTH-1:0] s2_data;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          s2_err   <= s1_err;
          s2_data  <= s1_data;
        end
      end

      assign rdout_valid = s2_valid;
      assign rdout_err   = s2_err;
      assign rdout_data  = s2_data;
    end
  endgenerate

endmodule

// File: tb/tb_pkt_slot_buffer.sv
// tb/tb_pkt_slot_buffer.sv - self-checking bench for pkt_slot_buffer against a queue-based model
module tb_pkt_slot_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_free;
  logic          rdout_valid;
  logic [DW-1:0] rdout_data;
  logic          rdout_err;
  logic [AW:0]   free_count;
  logic          init_done;

  always #5 clk = ~clk;

  pkt_slot_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .RD_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_addr     (wr_addr),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_addr     (rd_addr),
    .rd_free     (rd_free),
    .rdout_valid (rdout_valid),
    .rdout_data  (rdout_data),
    .rdout_err   (rdout_err),
    .free_count  (free_count),
    .init_done   (init_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    bit          err;
  } rd_entry_t;

  int            freeq[$];
  bit            alloc_m[DEPTH];
  logic [DW-1:0] mem_m[DEPTH];
  rd_entry_t     pend[$];
  bit            run;
  int            init_pushed;
  int            cyc = 0;

  task automatic model_reset();
    freeq.delete();
    pend.delete();
    foreach (alloc_m[i]) alloc_m[i] = 1'b0;
    run         = 1'b0;
    init_pushed = 0;
  endtask

  task automatic do_cycle(input bit wv, input logic [DW-1:0] wd, input bit rv,
                          input int ra, input bit rf);
    bit        exp_wr;
    bit        due_hit;
    bit        was;
    int        h;
    rd_entry_t e;
    wr_valid = wv;
    wr_data  = wd;
    rd_valid = rv;
    rd_addr  = ra[AW-1:0];
    rd_free  = rf;
    @(negedge clk);
    exp_wr = run && (freeq.size() != 0);
    chk("wr_ready", wr_ready, exp_wr);
    chk("rd_ready", rd_ready, run);
    chk("init_done", init_done, run);
    chk("free_count", free_count, freeq.size());
    if (exp_wr) chk("wr_addr", wr_addr, freeq[0]);
    due_hit = (pend.size() != 0) && (pend[0].due == cyc);
    chk("rdout_valid", rdout_valid, due_hit);
    if (due_hit) begin
      e = pend.pop_front();
      chk("rdout_err", rdout_err, e.err);
      if (!e.err) chk("rdout_data", rdout_data, e.data);
    end
    @(posedge clk);
    if (!run) begin
      freeq.push_back(init_pushed);
      init_pushed++;
      if (init_pushed == DEPTH) run = 1'b1;
    end else begin
      was = 1'b0;
      if (rv) begin
        was    = alloc_m[ra];
        e.due  = cyc + LAT;
        e.data = mem_m[ra];
        e.err  = !was;
        pend.push_back(e);
      end
      if (wv && exp_wr) begin
        h          = freeq.pop_front();
        mem_m[h]   = wd;
        alloc_m[h] = 1'b1;
      end
      if (rv && rf && was) begin
        alloc_m[ra] = 1'b0;
        freeq.push_back(ra);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) do_cycle(1'b0, '0, 1'b0, 0, 1'b0);
  endtask

  task automatic apply_reset(input int n);
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    rd_free  = 1'b0;
    #1;
    model_reset();
    chk("rst_free_count", free_count, 0);
    chk("rst_rdout_valid", rdout_valid, 0);
    chk("rst_rdout_data", rdout_data, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_ready", rd_ready, 0);
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_valid = 1'b0;
    rd_addr  = '0;
    rd_free  = 1'b0;
    #2;
    apply_reset(2);
    idle(5);

    for (int i = 0; i < 4; i++) do_cycle(1'b1, DW'(16'hA0 + i), 1'b0, 0, 1'b0);
    do_cycle(1'b1, DW'(16'hA4), 1'b0, 0, 1'b0);

    do_cycle(1'b0, '0, 1'b1, 2, 1'b0);
    idle(3);
    do_cycle(1'b0, '0, 1'b1, 2, 1'b1);
    idle(2);
    do_cycle(1'b1, DW'(16'hC2), 1'b0, 0, 1'b0);

    do_cycle(1'b1, DW'(16'hB0), 1'b1, 0, 1'b1);
    do_cycle(1'b1, DW'(16'hB0), 1'b0, 0, 1'b0);
    idle(1);
    do_cycle(1'b0, '0, 1'b1, 0, 1'b0);
    idle(2);

    do_cycle(1'b0, '0, 1'b1, 1, 1'b1);
    do_cycle(1'b0, '0, 1'b1, 1, 1'b1);
    idle(3);

    for (int i = 0; i < 4; i++) do_cycle(1'b0, '0, 1'b1, i, 1'b0);
    idle(3);

    do_cycle(1'b0, '0, 1'b1, 3, 1'b0);
    apply_reset(2);
    idle(6);

    for (int n = 0; n < 600; n++) begin
      if (n == 300) apply_reset(1);
      do_cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, DEPTH-1)), ($urandom_range(0, 2) == 0));
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pkt_slot_buffer.md
Name: pkt_slot_buffer

Overview:
Parametrised packet-payload slot buffer for the PIFO scheduler datapath. It generalises the single-port BRAM payload store into a managed buffer with these features:
- Owns a free list of slot addresses; on each write, hands back the allocated slot handle to the enqueue side.
- Serves reads by handle with a configurable fixed latency.
- Optionally releases the slot on read.
- Detects reads of, and frees of, unallocated slots.

The PIFO stores only the handle; this block stores the payload.

Parameters:
- DATA_WIDTH, 289, payload word width (tdata+tkeep+tlast packing)
- DEPTH, 64, number of slots; power of two, >=4
- ADDR_WIDTH, $clog2(DEPTH), slot handle width
- RD_LATENCY, 2, read request-to-data cycles; legal values 1 (unregistered RAM output) or 2 (output register)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- wr_valid  in  1  write request
- wr_ready  out  1  slot available and init done
- wr_data  in  DATA_WIDTH  payload to store
- wr_addr  out  ADDR_WIDTH  handle allocated to the current write; valid when wr_valid&&wr_ready
- rd_valid  in  1  read request
- rd_ready  out  1  read accepted; low only during init
- rd_addr  in  ADDR_WIDTH  handle to read
- rd_free  in  1  release slot with this read
- rdout_valid  out  1  read data valid, exactly RD_LATENCY cycles after accept
- rdout_data  out  DATA_WIDTH  read payload
- rdout_err  out  1  qualifies rdout_valid: handle was not allocated
- free_count  out  ADDR_WIDTH+1  number of free slots
- init_done  out  1  free list initialised

Behaviour:
- Reset (rst=0, async) drives outputs to the following values:
  - wr_ready=0, rd_ready=0, rdout_valid=0, rdout_err=0, rdout_data=0
  - free_count=0, init_done=0
  - alloc bitmap cleared
  - In-flight reads are discarded.
- Init after rst deasserts:
  - FSM goes INIT -> RUN.
  - INIT pushes handles 0..DEPTH-1 into the free-list FIFO, one per cycle: DEPTH cycles, counter-driven.
  - free_count increments per push.
  - On the last push: init_done=1 and state=RUN on the next edge.
- RUN is terminal until reset. rd_ready=1 in RUN. wr_ready = (free_count!=0).
- Write accept (wr_valid&&wr_ready):
  - wr_addr = free-list head, shown combinationally (first-word-fall-through).
  - RAM[wr_addr] <= wr_data.
  - Head is popped and alloc[wr_addr] <= 1.
  - free_count decrements.
- Read accept (rd_valid&&rd_ready):
  - RAM is read at rd_addr.
  - rdout_valid pulses RD_LATENCY cycles later. No output backpressure; the consumer must sink.
  - rdout_err = !alloc[rd_addr], sampled at accept and pipelined alongside the data.
- Free:
  - If rd_free=1 and alloc[rd_addr]=1: alloc cleared, handle pushed to the free list, free_count incremented, all at the accept edge.
  - If alloc[rd_addr]=0: no push (double-free protection), rdout_err=1.
- Simultaneous write-alloc and read-free in one cycle: both take effect; free_count unchanged.
  - A freed handle is not reusable in the same cycle; it becomes visible at the head no earlier than the next cycle.
- Read and write of the same address in one cycle: read returns the old RAM contents (read-first); no bypass.
- Read by a valid handle without rd_free: data returned, slot stays allocated. Repeated reads are legal (multicast/retransmit).
- free_count saturation: the free list can never exceed DEPTH, because push requires a set alloc bit. No overflow path exists.
- Full (free_count=0): wr_ready=0 that cycle; wr_data is ignored.
- Reset mid-operation: all state is lost, INIT repeats, stale rdout pulses are suppressed.

Decomposition:
- Shared package pifo_buf_pkg:
  - slot handle typedef
  - FSM state enum {INIT, RUN}
  - RD_LATENCY legal-value constants
  - default DATA_WIDTH
- One sub-module, slot_free_list: FIFO of ADDR_WIDTH entries, DEPTH deep.
  - Interfaces: push/pop, first-word-fall-through head, count.
- Storage is an inferred simple-dual-port RAM in the top.

Test Plan:
- DEPTH=4, release reset -> init_done rises exactly 4 cycles after rst deasserts; free_count=4; wr_ready=1.
- 4 back-to-back writes of 0xA0..0xA3 -> wr_addr 0,1,2,3; free_count=0; wr_ready=0 on the 5th cycle, and the 5th write (0xA4) is not stored.
- With RD_LATENCY=2, read handle 2 with rd_free=0 -> rdout_data=0xA2 at exactly +2 cycles; free_count stays 0. Repeat the read with rd_free=1 -> free_count=1; next write gets wr_addr=2.
- Full buffer, same cycle write 0xB0 and read-free handle 0 -> write stalls (wr_ready=0). Next cycle the write is accepted with wr_addr=0, and a later read of handle 0 returns 0xB0.
- Read-free handle 1 twice -> first read rdout_err=0; second read rdout_err=1; free_count incremented only once.
- Assert rst=0 while a read is in flight -> no rdout_valid emitted; free_count=0 immediately; INIT re-runs to free_count=4.
